// File: rtl/shift_deserializer_if.sv
// Beat-side and word-side handshake bundle for the narrow-to-wide deserializer.
// No logic or latency: the bundle only groups the signals.
// Backpressure is carried by ready_o (toward the serial source) and ready_i (from the sink).
interface shift_deserializer_if #(
  parameter int FROM = 4,
  parameter int TO   = 32
);
  logic [FROM-1:0] data_i;
  logic            valid_i;
  logic            ready_o;
  logic [TO-1:0]   data_o;
  logic            valid_o;
  logic            ready_i;

  // Environment side: drives serial beats and the sink's ready.
  modport master (
    output data_i, valid_i, ready_i,
    input  ready_o, data_o, valid_o
  );

  // Deserializer side.
  modport slave (
    input  data_i, valid_i, ready_i,
    output ready_o, data_o, valid_o
  );
endinterface

// File: rtl/shift_deserializer.sv
// Collects TO/FROM serial beats (most-significant chunk first) into one TO-bit word.
// Latency: valid_o rises the cycle after the last beat of a word is accepted.
// Backpressure: a single output holding register; only the last beat of a word stalls while it is occupied.
// Optional start-of-frame resync and sync-error pulse: define SHIFT_DESER_SOF_EN.
module shift_deserializer #(
  parameter int FROM      = 4,
  parameter int TO        = 32,
  parameter int LOG2RATIO = 3
) (
  input  logic clk,
  input  logic reset,
`ifdef SHIFT_DESER_SOF_EN
  input  logic sof_i,
  output logic sync_err_o,
`endif
  shift_deserializer_if.slave des
);

  localparam int RATIO = TO / FROM;
  localparam logic [LOG2RATIO-1:0] LAST = LOG2RATIO'(RATIO - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    VALID = 1'b1
  } state_t;

  state_t               state, state_nxt;
  logic [LOG2RATIO-1:0] cnt, cnt_nxt;
  logic [TO-1:0]        shift_reg, shift_nxt;
  logic [TO-1:0]        out_reg;
  logic                 rdy;
  logic                 beat_acc;
  logic                 sof_beat;
  logic                 word_done;

  // Only the word-completing beat can be held off, and only by an occupied output register;
  // both terms are registered, so ready_o never depends on ready_i or valid_i.
  assign rdy         = !(state == VALID && cnt == LAST);
  assign des.ready_o = rdy;
  assign des.valid_o = (state == VALID);
  assign des.data_o  = out_reg;
  assign beat_acc    = des.valid_i && rdy;

`ifdef SHIFT_DESER_SOF_EN
  logic sync_err_q;

  // A start-of-frame beat always restarts the word, so it can never complete one.
  assign sof_beat   = beat_acc && sof_i;
  assign sync_err_o = sync_err_q;

  // Pulse for one cycle when a start-of-frame beat cuts a partial word short.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_err_q <= 1'b0;
    end else begin
      sync_err_q <= sof_beat && (cnt != '0);
    end
  end
`else
  assign sof_beat = 1'b0;
`endif

  assign word_done = beat_acc && !sof_beat && (cnt == LAST);

  // Beat counter and shift register advance on every accepted beat; gaps freeze both.
  always_comb begin
    cnt_nxt   = cnt;
    shift_nxt = shift_reg;
    if (sof_beat) begin
      cnt_nxt   = LOG2RATIO'(1);
      shift_nxt = {{(TO-FROM){1'b0}}, des.data_i};
    end else if (beat_acc) begin
      cnt_nxt   = (cnt == LAST) ? '0 : cnt + 1'b1;
      shift_nxt = {shift_reg[TO-FROM-1:0], des.data_i};
    end
  end

  // Collection state plus the output holding register, loaded with the completed word.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      shift_reg <= '0;
      out_reg   <= '0;
    end else begin
      cnt       <= cnt_nxt;
      shift_reg <= shift_nxt;
      if (word_done) begin
        out_reg <= {shift_reg[TO-FROM-1:0], des.data_i};
      end
    end
  end

  // Output occupancy state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Completion is the only way into VALID; a completion coinciding with a sink handshake keeps it VALID.
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: begin
        if (word_done) state_nxt = VALID;
      end
      VALID: begin
        if (word_done)        state_nxt = VALID;
        else if (des.ready_i) state_nxt = EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase
  end

endmodule

// File: tb/tb_shift_deserializer.sv
// Randomized and directed stimulus for shift_deserializer against a queue-based reference model.
// The monitor samples on the falling edge and scores ready_o, valid_o, data_o (and sync_err_o).
// Sink ready is driven directly, randomly toggled in the random phase.
module tb_shift_deserializer;
  localparam int FROM  = 4;
  localparam int TO    = 32;
  localparam int RATIO = TO / FROM;

  logic clk;
  logic reset;
  logic sof;
`ifdef SHIFT_DESER_SOF_EN
  logic sync_err;
  logic exp_err;
`endif

  shift_deserializer_if #(.FROM(FROM), .TO(TO)) bus ();

  shift_deserializer #(.FROM(FROM), .TO(TO), .LOG2RATIO(3)) dut (
    .clk        (clk),
    .reset      (reset),
`ifdef SHIFT_DESER_SOF_EN
    .sof_i      (sof),
    .sync_err_o (sync_err),
`endif
    .des        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic rand_rdy = 1'b0;

  // Reference model state: beats of the word in progress, and completed words awaiting the sink.
  logic [FROM-1:0] beats[$];
  logic [TO-1:0]   sb[$];
  logic            exp_rdy;
  logic [TO-1:0]   w;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // Monitor and model: score the current cycle, then apply this cycle's handshakes to the model.
  always @(negedge clk) begin
    if (reset) begin
      beats.delete();
      sb.delete();
`ifdef SHIFT_DESER_SOF_EN
      exp_err = 1'b0;
`endif
    end else begin
      exp_rdy = !(sb.size() != 0 && beats.size() == RATIO - 1);
      check("ready_o", 32'(bus.ready_o), 32'(exp_rdy));
      check("valid_o", 32'(bus.valid_o), 32'(sb.size() != 0));
      if (sb.size() != 0) begin
        check("data_o", bus.data_o, sb[0]);
        if (bus.ready_i) void'(sb.pop_front());
      end
`ifdef SHIFT_DESER_SOF_EN
      check("sync_err_o", 32'(sync_err), 32'(exp_err));
      exp_err = 1'b0;
`endif
      if (bus.valid_i && exp_rdy) begin
        if (sof) begin
`ifdef SHIFT_DESER_SOF_EN
          if (beats.size() != 0) exp_err = 1'b1;
`endif
          beats.delete();
        end
        beats.push_back(bus.data_i);
        if (beats.size() == RATIO) begin
          w = '0;
          foreach (beats[k]) w = w * (1 << FROM) + TO'(beats[k]);
          sb.push_back(w);
          beats.delete();
        end
      end
    end
  end

  // Present one beat and hold it until accepted (bounded).
  task automatic push_beat(input logic [FROM-1:0] d, input logic s);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    bus.data_i  = d;
    bus.valid_i = 1'b1;
    sof         = s;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = bus.ready_o;
      @(posedge clk);
      #1;
      n++;
      if (rand_rdy) bus.ready_i = 1'($urandom_range(0, 1));
    end
    check("beat_accept", 32'(acc), 32'd1);
    bus.valid_i = 1'b0;
    sof         = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [TO-1:0] word, input int gap);
    logic [TO-1:0] t;
    t = word;
    for (int k = 0; k < RATIO; k++) begin
      push_beat(t[TO-1 -: FROM], 1'b0);
      t = t << FROM;
      if (gap > 0) idle(gap);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    idle(n);
    reset = 1'b0;
  endtask

  initial begin
    logic [TO-1:0] t;
    int            drain;
    reset       = 1'b1;
    sof         = 1'b0;
    bus.data_i  = '0;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    idle(3);
    reset = 1'b0;

    // Reset state.
    @(negedge clk);
    check("reset_valid_o", 32'(bus.valid_o), 32'd0);
    check("reset_data_o", bus.data_o, 32'h0);
    check("reset_ready_o", 32'(bus.ready_o), 32'd1);
    @(posedge clk);
    #1;

    // Single word then back-to-back words at full rate.
    send_word(32'hDEADBEEF, 0);
    send_word(32'h12345678, 0);
    send_word(32'h9ABCDEF0, 0);
    idle(3);

    // Backpressure: first word parks in the holding register, last beat of the next one waits.
    bus.ready_i = 1'b0;
    send_word(32'hDEADBEEF, 0);
    t = 32'hCAFEF00D;
    for (int k = 0; k < RATIO - 1; k++) begin
      push_beat(t[TO-1 -: FROM], 1'b0);
      t = t << FROM;
    end
    fork
      push_beat(t[TO-1 -: FROM], 1'b0);
      begin
        idle(4);
        bus.ready_i = 1'b1;
      end
    join
    idle(3);

    // Gapped input: valid_i alternates with idle cycles.
    send_word(32'h0F0F0F0F, 1);
    idle(3);

    // Reset in the middle of a word, then a clean word.
    push_beat(4'h7, 1'b0);
    push_beat(4'h7, 1'b0);
    push_beat(4'h7, 1'b0);
    do_reset(2);
    send_word(32'h11223344, 0);
    idle(3);

    // Reset while a completed word is still held by a stalled sink.
    bus.ready_i = 1'b0;
    send_word(32'h55667788, 0);
    do_reset(1);
    bus.ready_i = 1'b1;
    idle(2);

`ifdef SHIFT_DESER_SOF_EN
    // Start-of-frame cutting a partial word, then a clean framed word.
    for (int k = 0; k < 5; k++) push_beat(4'($urandom_range(0, 15)), 1'b0);
    push_beat(4'hA, 1'b1);
    t = 32'h5A5A5A50;
    for (int k = 0; k < RATIO - 1; k++) begin
      push_beat(t[TO-1 -: FROM], 1'b0);
      t = t << FROM;
    end
    idle(2);
    push_beat(4'h1, 1'b1);
    t = 32'h23456780;
    for (int k = 0; k < RATIO - 1; k++) begin
      push_beat(t[TO-1 -: FROM], 1'b0);
      t = t << FROM;
    end
    idle(3);
`endif

    // Random words with random gaps and a randomly stalling sink.
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      t = $urandom;
      for (int k = 0; k < RATIO; k++) begin
        push_beat(t[TO-1 -: FROM], 1'b0);
        t = t << FROM;
        idle($urandom_range(0, 2));
      end
    end
    rand_rdy    = 1'b0;
    bus.ready_i = 1'b1;

    // Drain any word still held.
    drain = 0;
    while (sb.size() != 0 && drain < 50) begin
      idle(1);
      drain++;
    end
    check("drain", 32'(sb.size()), 32'd0);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
